// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, x0 address and queue entry type for the register file writeback path
package regfile_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_match.sv
// wbq_match: youngest-entry address match over a circular write queue
// Ports: valid_i/addr_i/data_i entry arrays, head_i oldest slot, lookup_i read address,
//        hit_o any valid match, data_o data of the youngest match (0 when none or lookup is x0)
module wbq_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [AW-1:0]          addr_i [DEPTH],
  input  logic [DW-1:0]          data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [AW-1:0]          lookup_i,
  output logic                   hit_o,
  output logic [DW-1:0]          data_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the last match written is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && addr_i[idx] == lookup_i && lookup_i != AW'(REG_ZERO)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback FIFO feeding the register file write port, with read bypass
// Ports: wb_valid/wb_ready/wb_addr/wb_data writeback handshake; rf_stall/rf_we/rf_addr/rf_wdata
//        write port (WE3/A3/WD3); rs1_addr/rs2_addr read addresses with rs*_hit/rs*_data bypass;
//        count pending entries. Bypass match logic only exists when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DW-1:0]            wb_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_addr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            rs1_addr,
  input  logic [AW-1:0]            rs2_addr,
  output logic                     rs1_hit,
  output logic [DW-1:0]            rs1_data,
  output logic                     rs2_hit,
  output logic [DW-1:0]            rs2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic             push, pop, empty;
  // wb_ready looks only at the registered count so rf_stall never reaches it combinationally.
  always_comb begin
    empty    = count_q == '0;
    wb_ready = count_q != (PW+1)'(DEPTH);
    rf_we    = ~empty & ~rf_stall;
    rf_addr  = empty ? '0 : addr_q[head_q];
    rf_wdata = empty ? '0 : data_q[head_q];
    push     = wb_valid & wb_ready & (wb_addr != AW'(REG_ZERO));
    pop      = rf_we;
    head_d   = pop ? head_q + PW'(1) : head_q;
    tail_d   = push ? tail_q + PW'(1) : tail_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    valid_d  = valid_q;
    if (push) valid_d[tail_q] = 1'b1;
    if (pop) valid_d[head_q] = 1'b0;
  end
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wb_addr;
      data_q[tail_q] <= wb_data;
    end
  end
`ifdef REGFILE_WB_BYPASS_EN
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rs1 (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .data_i  (data_q),
    .head_i  (head_q),
    .lookup_i(rs1_addr),
    .hit_o   (rs1_hit),
    .data_o  (rs1_data)
  );
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rs2 (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .data_i  (data_q),
    .head_i  (head_q),
    .lookup_i(rs2_addr),
    .hit_o   (rs2_hit),
    .data_o  (rs2_data)
  );
`else
  logic unused_rs;
  assign unused_rs = ^{rs1_addr, rs2_addr};
  assign rs1_hit   = 1'b0;
  assign rs1_data  = '0;
  assign rs2_hit   = 1'b0;
  assign rs2_data  = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed table plus randomized traffic checked against a queue model
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, wb_valid, wb_ready, rf_stall, rf_we, rs1_hit, rs2_hit;
  logic [4:0]  wb_addr, rf_addr, rs1_addr, rs2_addr;
  logic [31:0] wb_data, rf_wdata, rs1_data, rs2_data;
  logic [2:0]  count;
  int          vectors = 0;
  int          errors = 0;
  bit          model_ok = 1'b0;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  typedef struct {
    bit          chk;
    logic        rst, valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [4:0]  rs1;
    logic [2:0]  cnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready, hit1;
    logic [31:0] d1;
  } vec_t;
  vec_t tbl[$];

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_hit(rs1_hit), .rs1_data(rs1_data), .rs2_hit(rs2_hit), .rs2_data(rs2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic look(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (BYP && a != 0)
      foreach (q[i])
        if (q[i].a == a) begin
          h = 1'b1;
          d = q[i].d;
        end
  endtask

  task automatic settle();
    logic        h;
    logic [31:0] d;
    int          n;
    @(negedge clk);
    if (model_ok) begin
      n = q.size();
      check("m_ready", wb_ready, 32'(n < DEPTH));
      check("m_rf_we", rf_we, 32'(n != 0 && !rf_stall));
      check("m_count", count, n);
      if (n != 0) begin
        check("m_rf_addr", rf_addr, q[0].a);
        check("m_rf_wdata", rf_wdata, q[0].d);
      end else begin
        check("m_rf_addr", rf_addr, 0);
        check("m_rf_wdata", rf_wdata, 0);
      end
      look(rs1_addr, h, d);
      check("m_rs1_hit", rs1_hit, h);
      check("m_rs1_data", rs1_data, d);
      look(rs2_addr, h, d);
      check("m_rs2_hit", rs2_hit, h);
      check("m_rs2_data", rs2_data, d);
    end
  endtask

  task automatic advance();
    bit   pop, push;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      pop  = q.size() != 0 && !rf_stall;
      push = wb_valid && q.size() < DEPTH && wb_addr != 0;
      if (pop) void'(q.pop_front());
      if (push) begin
        e.a = wb_addr;
        e.d = wb_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    //             chk rst v  addr  data      st rs1 | cnt we wa  wdata    rdy hit d1
    tbl.push_back('{0, 1, 0, 0,  32'h0,     0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 9,  32'h20,    0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 9,    1, 1, 9,  32'h20,  1, 1, 32'h20});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 9,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 0,  32'hDEAD,  0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 6,  32'h2,     1, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 5,  32'h3,     1, 6,    1, 0, 6,  32'h2,   1, 1, 32'h2});
    tbl.push_back('{1, 0, 1, 6,  32'h7,     1, 0,    2, 0, 6,  32'h2,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 7,  32'h1,     1, 6,    3, 0, 6,  32'h2,   1, 1, 32'h7});
    tbl.push_back('{1, 0, 1, 9,  32'h55,    1, 6,    4, 0, 6,  32'h2,   0, 1, 32'h7});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     1, 7,    4, 0, 6,  32'h2,   0, 1, 32'h1});
    tbl.push_back('{1, 0, 1, 9,  32'h55,    0, 6,    4, 1, 6,  32'h2,   0, 1, 32'h7});
    tbl.push_back('{1, 0, 1, 9,  32'h55,    0, 5,    3, 1, 5,  32'h3,   1, 1, 32'h3});
    tbl.push_back('{1, 0, 1, 10, 32'hA,     0, 9,    3, 1, 6,  32'h7,   1, 1, 32'h55});
    tbl.push_back('{1, 0, 1, 11, 32'hB,     0, 6,    3, 1, 7,  32'h1,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 0,    3, 1, 9,  32'h55,  1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 0,    2, 1, 10, 32'hA,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 12, 32'hC,     1, 0,    1, 0, 11, 32'hB,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 13, 32'hD,     1, 0,    2, 0, 11, 32'hB,   1, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0,  32'h0,     1, 13,   3, 0, 11, 32'hB,   1, 1, 32'hD});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 13,   0, 0, 0,  32'h0,   1, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0,  32'h0,     0, 0,    0, 0, 0,  32'h0,   1, 0, 32'h0});
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    rf_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; wb_valid = tbl[i].valid; wb_addr = tbl[i].addr; wb_data = tbl[i].data;
      rf_stall = tbl[i].stall; rs1_addr = tbl[i].rs1; rs2_addr = '0;
      settle();
      if (tbl[i].chk) begin
        check($sformatf("t%0d_count", i), count, tbl[i].cnt);
        check($sformatf("t%0d_rf_we", i), rf_we, tbl[i].we);
        check($sformatf("t%0d_rf_addr", i), rf_addr, tbl[i].waddr);
        check($sformatf("t%0d_rf_wdata", i), rf_wdata, tbl[i].wdata);
        check($sformatf("t%0d_ready", i), wb_ready, tbl[i].ready);
        check($sformatf("t%0d_rs1_hit", i), rs1_hit, tbl[i].hit1 & BYP);
        check($sformatf("t%0d_rs1_data", i), rs1_data, BYP ? tbl[i].d1 : 32'h0);
      end
      advance();
    end
    for (int i = 0; i < 600; i++) begin
      rst      = $urandom_range(63) == 0;
      wb_valid = $urandom_range(1);
      wb_addr  = 5'($urandom_range(7));
      wb_data  = $urandom;
      rf_stall = ((i / 40) % 2 == 1) ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
      rs1_addr = 5'($urandom_range(7));
      rs2_addr = 5'($urandom_range(7));
      settle();
      advance();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
